// File: rtl/alu_result_stage.sv
// Result stage behind the 16-bit ALU: 2-entry skid buffer feeding writeback,
// plus architectural flags, sticky overflow and retired-result counter.
`timescale 1ns/1ps
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_zero,
  input  logic             in_ovfl,
  input  logic [OPW-1:0]   in_op,
  input  logic [TAGW-1:0]  in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_ovfl,
  output logic [TAGW-1:0]  out_dest,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             ovfl_sticky,
  input  logic             clr_sticky,
  output logic [15:0]      retired_cnt
);

  localparam int EW = WIDTH + 2 + OPW + TAGW;
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);

  // e0 is always the head slot; e1 only holds data when two entries are queued
  logic [EW-1:0]    e0_q, e0_d, e1_q, e1_d, in_entry;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             fz_q, fz_d, fn_q, fn_d, fv_q, fv_d, stk_q, stk_d;
  logic [15:0]      ret_q, ret_d;
  logic [OPW-1:0]   head_op;
  logic             push, pop, is_addsub;

  assign in_entry  = {in_r, in_zero, in_ovfl, in_op, in_dest};
  assign out_r     = e0_q[EW-1 -: WIDTH];
  assign out_zero  = e0_q[OPW+TAGW+1];
  assign out_ovfl  = e0_q[OPW+TAGW];
  assign head_op   = e0_q[TAGW +: OPW];
  assign out_dest  = e0_q[TAGW-1:0];

  assign out_valid = (cnt_q != 2'd0);
  assign in_ready  = rdy_q;
  assign push      = in_valid & rdy_q;
  assign pop       = out_valid & out_ready;
  assign is_addsub = (head_op == OP_ADD) || (head_op == OP_SUB);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = in_entry;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = in_entry;
        end else if (push) begin
          e1_d  = in_entry;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d  = e1_q;
          cnt_d = 2'd1;
        end
      end
    endcase
    rdy_d = (cnt_d != 2'd2);
  end

  always_comb begin
    fz_d  = fz_q;
    fn_d  = fn_q;
    fv_d  = fv_q;
    ret_d = ret_q;
    stk_d = stk_q;
    if (clr_sticky) stk_d = 1'b0;
    if (pop) begin
      fz_d  = out_zero;
      fn_d  = out_r[WIDTH-1];
      fv_d  = is_addsub & out_ovfl;
      ret_d = ret_q + 16'd1;
      // a setting retire beats a same-cycle clear
      if (is_addsub && out_ovfl) stk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
      fz_q  <= 1'b0;
      fn_q  <= 1'b0;
      fv_q  <= 1'b0;
      stk_q <= 1'b0;
      ret_q <= 16'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      fz_q  <= fz_d;
      fn_q  <= fn_d;
      fv_q  <= fv_d;
      stk_q <= stk_d;
      ret_q <= ret_d;
    end
  end

  assign flag_z      = fz_q;
  assign flag_n      = fn_q;
  assign flag_v      = fv_q;
  assign ovfl_sticky = stk_q;
  assign retired_cnt = ret_q;

endmodule
